pipeline_hazard_ctrl: RTL and testbench

Central hazard and stall sequencer for the 5-stage pipelined MIPS core. Every cycle it decides whether the PC, IF/ID, ID/EX and EX/MEM pipeline registers capture, hold or flush. It handles three conditions: load-use data hazards with a configurable bubble count, taken branches resolved in EX, and multi-cycle data-memory waits. All pipeline-register write-enable and flush strobes in the core come from this block.

---
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use bubbles, EX branch flushes, data-memory waits.
// Optional performance counters are compiled in when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_write,
  output logic       id_ex_flush,
  output logic       ex_mem_write,
  output logic       mem_wb_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  // Strobe vector order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}
  localparam logic [6:0] STB_NOMINAL = 7'b1101010;
  localparam logic [6:0] STB_BRANCH  = 7'b1111110;
  localparam logic [6:0] STB_FREEZE  = 7'b0000001;
  localparam logic [6:0] STB_BUBBLE  = 7'b0001110;
  localparam logic [6:0] STB_RESET   = 7'b0010101;
  localparam logic [1:0] LU_INIT     = 2'(LOAD_USE_STALLS - 1);

  state_t     state, state_nxt;
  logic [1:0] lu_cnt, lu_cnt_nxt;
  logic       ret_state, ret_state_nxt;   // 1 = return to LU_STALL, 0 = return to RUN
  logic [6:0] strobes;
  logic       branch_flush;
  logic       lu, mw;
  logic       active, as_lu, mw_eff;

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mw = mem_req && !mem_ready;

  always_comb begin
    state_nxt     = state;
    lu_cnt_nxt    = lu_cnt;
    ret_state_nxt = ret_state;
    strobes       = STB_NOMINAL;
    branch_flush  = 1'b0;
    active        = 1'b1;
    as_lu         = 1'b0;
    mw_eff        = mw;

    // MEM_WAIT replays the interrupted state once the memory completes.
    case (state)
      LU_STALL: as_lu = 1'b1;
      MEM_WAIT: begin
        active = mem_ready;
        as_lu  = ret_state;
        mw_eff = 1'b0;
      end
      default: as_lu = 1'b0;
    endcase

    if (!active) begin
      strobes = STB_FREEZE;
    end else if (mw_eff) begin
      strobes       = STB_FREEZE;
      ret_state_nxt = as_lu;
      state_nxt     = MEM_WAIT;
    end else if (as_lu) begin
      strobes    = STB_BUBBLE;
      lu_cnt_nxt = lu_cnt - 2'd1;
      state_nxt  = (lu_cnt == 2'd1) ? RUN : LU_STALL;
    end else if (ex_branch_taken) begin
      strobes      = STB_BRANCH;
      branch_flush = 1'b1;
      state_nxt    = RUN;
    end else if (lu) begin
      strobes = STB_BUBBLE;
      if (LOAD_USE_STALLS > 1) begin
        lu_cnt_nxt = LU_INIT;
        state_nxt  = LU_STALL;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      state_nxt = RUN;
    end

    // Reset overrides the strobes without waiting for a clock edge.
    if (reset) begin
      strobes      = STB_RESET;
      branch_flush = 1'b0;
    end
  end

  assign {pc_write, if_id_write, if_id_flush, id_ex_write,
          id_ex_flush, ex_mem_write, mem_wb_flush} = strobes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      lu_cnt    <= 2'd0;
      ret_state <= 1'b0;
    end else begin
      state     <= state_nxt;
      lu_cnt    <= lu_cnt_nxt;
      ret_state <= ret_state_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!pc_write && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (branch_flush && (flush_events != 32'hFFFF_FFFF))
        flush_events <= flush_events + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = branch_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1 and 3 load-use bubbles) driven by shared inputs,
// checked against a count-based reference model; define HAZARD_PERF_CNT_EN to cover the counters.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] E_NOM = 7'b1101010;
  localparam logic [6:0] E_BR  = 7'b1111110;
  localparam logic [6:0] E_FRZ = 7'b0000001;
  localparam logic [6:0] E_BUB = 7'b0001110;
  localparam logic [6:0] E_RST = 7'b0010101;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

  logic [1:0] pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f;
  logic [6:0] obs_o [2];
  logic [31:0] stall_o [2];
  logic [31:0] flush_o [2];

  int compared = 0;
  int mismatched = 0;

  // Reference model: remaining bubbles and a "waiting on memory" flag per instance.
  int          n_tab [2] = '{1, 3};
  bit          m_wait [2];
  int          m_left [2];
  int          m_stall [2];
  int          m_flush [2];
  logic [6:0]  exp_o [2];
  bit          nx_wait [2];
  int          nx_left [2];
  bit          nx_inc [2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_USE_STALLS(1)) dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_w[0]), .if_id_write(ifid_w[0]), .if_id_flush(ifid_f[0]),
    .id_ex_write(idex_w[0]), .id_ex_flush(idex_f[0]), .ex_mem_write(exmem_w[0]),
    .mem_wb_flush(memwb_f[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_o[0]), .flush_events(flush_o[0])
`endif
  );

  pipeline_hazard_ctrl #(.LOAD_USE_STALLS(3)) dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_w[1]), .if_id_write(ifid_w[1]), .if_id_flush(ifid_f[1]),
    .id_ex_write(idex_w[1]), .id_ex_flush(idex_f[1]), .ex_mem_write(exmem_w[1]),
    .mem_wb_flush(memwb_f[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_o[1]), .flush_events(flush_o[1])
`endif
  );

`ifndef HAZARD_PERF_CNT_EN
  assign stall_o[0] = 32'd0;
  assign stall_o[1] = 32'd0;
  assign flush_o[0] = 32'd0;
  assign flush_o[1] = 32'd0;
`endif

  assign obs_o[0] = {pc_w[0], ifid_w[0], ifid_f[0], idex_w[0], idex_f[0], exmem_w[0], memwb_f[0]};
  assign obs_o[1] = {pc_w[1], ifid_w[1], ifid_f[1], idex_w[1], idex_f[1], exmem_w[1], memwb_f[1]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mrd, input logic [4:0] ert, input logic br,
                       input logic mreq, input logic mrdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd; ex_rt = ert;
    ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_eval();
    bit lu, mw;
    lu = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mw = mem_req && !mem_ready;
    for (int k = 0; k < 2; k++) begin
      nx_wait[k] = m_wait[k];
      nx_left[k] = m_left[k];
      nx_inc[k]  = 1'b0;
      if (reset) begin
        exp_o[k] = E_RST; nx_wait[k] = 1'b0; nx_left[k] = 0;
      end else if (m_wait[k] && !mem_ready) begin
        exp_o[k] = E_FRZ;
      end else if (!m_wait[k] && mw) begin
        exp_o[k] = E_FRZ; nx_wait[k] = 1'b1;
      end else begin
        nx_wait[k] = 1'b0;
        if (m_left[k] > 0) begin
          exp_o[k] = E_BUB; nx_left[k] = m_left[k] - 1;
        end else if (ex_branch_taken) begin
          exp_o[k] = E_BR; nx_inc[k] = 1'b1;
        end else if (lu) begin
          exp_o[k] = E_BUB; nx_left[k] = n_tab[k] - 1;
        end else begin
          exp_o[k] = E_NOM;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 1'b0; m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, "_n1"}, 32'(obs_o[0]), 32'(exp_o[0]));
    chk({tag, "_n3"}, 32'(obs_o[1]), 32'(exp_o[1]));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_wait[k] = 1'b0; m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        if (exp_o[k][6] == 1'b0) m_stall[k]++;
        if (nx_inc[k]) m_flush[k]++;
        m_wait[k] = nx_wait[k];
        m_left[k] = nx_left[k];
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    #1;
    chk({tag, "_stall_n3"}, stall_o[1], 32'(m_stall[1]));
    chk({tag, "_flush_n3"}, flush_o[1], 32'(m_flush[1]));
`endif
    @(negedge clk);
  endtask

  initial begin
    // Reset phase
    idle();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_n1", 32'(obs_o[0]), 32'(E_RST));
    chk("rst_n3", 32'(obs_o[1]), 32'(E_RST));
    chk("rst_stall", stall_o[1], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(); step("idle");

    // Load-use on rs, then ex_rt = 0 never hazards
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); step("lu_rs");
    idle(); step("lu_rs_a1");
    idle(); step("lu_rs_a2");
    idle(); step("lu_rs_a3");
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); step("lu_r0");

    // Hazard on rt with id_uses_rt, then same without it
    drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); step("lu_rt");
    for (int i = 0; i < 3; i++) begin idle(); step("lu_rt_after"); end
    drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); step("lu_rt_unused");

    // Taken branch together with a load-use
    drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); step("br_lu");
    idle(); step("br_after");

    // Memory wait of 4 cycles starting in the 2nd bubble
    drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0); step("mwlu_b1");
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step("mwlu_frz");
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); step("mwlu_rel");
    for (int i = 0; i < 2; i++) begin idle(); step("mwlu_tail"); end

    // Asynchronous reset in the middle of a memory wait
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step("arst_mw0");
    step("arst_mw1");
    #2 reset = 1'b1;
    #1;
    chk("arst_n1", 32'(obs_o[0]), 32'(E_RST));
    chk("arst_n3", 32'(obs_o[1]), 32'(E_RST));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(); step("arst_post");

    // Counter scenario: 3-cycle load-use plus one branch since reset
    drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0); step("perf_lu");
    idle(); step("perf_b2");
    idle(); step("perf_b3");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); step("perf_br");
    idle(); step("perf_idle");
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall3", stall_o[1], 32'd3);
    chk("perf_flush3", flush_o[1], 32'd1);
    chk("perf_stall1", stall_o[0], 32'd1);
    chk("perf_flush1", flush_o[0], 32'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 80) == 0);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      step("rand");
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
